lpc_host: RTL and testbench

LPC_HOST -- requirements
Module: lpc_host

---
 rtl/lpc_host.sv | 220 ++++++++++++++++++++++
 tb/tb_lpc_host.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lpc_host.sv
// rtl/lpc_host.sv - LPC host for single I/O read/write cycles with SYNC timeout abort
`timescale 1ns/1ps

module lpc_host #(
  parameter int SYNC_TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        nrst_i,
  output logic        lframe_o,
  inout  wire  [3:0]  lad_bus,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_wr_i,
  input  logic [15:0] req_addr_i,
  input  logic [7:0]  req_data_i,
  output logic        done_o,
  output logic [7:0]  rsp_data_o,
  output logic [1:0]  rsp_status_o,
  output logic        busy_o
);

  localparam int CW = $clog2(SYNC_TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(SYNC_TIMEOUT);

  typedef enum logic [4:0] {
    S_IDLE,
    S_START,
    S_CYCTYPE,
    S_ADDR0,
    S_ADDR1,
    S_ADDR2,
    S_ADDR3,
    S_WDATA0,
    S_WDATA1,
    S_HTAR1,
    S_HTAR2,
    S_SYNC,
    S_RDATA0,
    S_RDATA1,
    S_PTAR1,
    S_PTAR2,
    S_ABORT,
    S_ABORT_IDLE
  } state_t;

  state_t          state;
  state_t          state_nxt;

  // request fields frozen at acceptance so later req_* changes cannot leak in
  logic            lat_wr;
  logic [15:0]     lat_addr;
  logic [7:0]      lat_data;

  logic [CW-1:0]   sync_cnt;
  logic [CW-1:0]   sync_cnt_inc;
  logic [1:0]      abort_cnt;
  logic [1:0]      pend_status;
  logic [7:0]      rd_shadow;

  logic            lad_oe;
  logic [3:0]      lad_out;
  logic            sync_end;
  logic            sync_err;
  logic            sync_counted;
  logic            go_abort;
  logic            accept;

  assign lad_bus      = lad_oe ? lad_out : 4'bzzzz;
  assign req_ready_o  = (state == S_IDLE);
  assign busy_o       = (state != S_IDLE);
  assign accept       = req_valid_i && req_ready_o;
  assign sync_cnt_inc = (sync_cnt == LIMIT) ? LIMIT : sync_cnt + 1'b1;

  // state register
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state decode, LAD/LFRAME# drive and SYNC classification
  always_comb begin
    state_nxt    = state;
    lframe_o     = 1'b1;
    lad_oe       = 1'b0;
    lad_out      = 4'h0;
    sync_end     = 1'b0;
    sync_err     = 1'b0;
    sync_counted = 1'b0;
    go_abort     = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid_i) state_nxt = S_START;
      end
      S_START: begin
        lframe_o  = 1'b0;
        lad_oe    = 1'b1;
        lad_out   = 4'h0;
        state_nxt = S_CYCTYPE;
      end
      S_CYCTYPE: begin
        lad_oe    = 1'b1;
        lad_out   = lat_wr ? 4'h2 : 4'h0;
        state_nxt = S_ADDR0;
      end
      S_ADDR0: begin
        lad_oe    = 1'b1;
        lad_out   = lat_addr[15:12];
        state_nxt = S_ADDR1;
      end
      S_ADDR1: begin
        lad_oe    = 1'b1;
        lad_out   = lat_addr[11:8];
        state_nxt = S_ADDR2;
      end
      S_ADDR2: begin
        lad_oe    = 1'b1;
        lad_out   = lat_addr[7:4];
        state_nxt = S_ADDR3;
      end
      S_ADDR3: begin
        lad_oe    = 1'b1;
        lad_out   = lat_addr[3:0];
        state_nxt = lat_wr ? S_WDATA0 : S_HTAR1;
      end
      S_WDATA0: begin
        lad_oe    = 1'b1;
        lad_out   = lat_data[3:0];
        state_nxt = S_WDATA1;
      end
      S_WDATA1: begin
        lad_oe    = 1'b1;
        lad_out   = lat_data[7:4];
        state_nxt = S_HTAR1;
      end
      S_HTAR1: begin
        lad_oe    = 1'b1;
        lad_out   = 4'hF;
        state_nxt = S_HTAR2;
      end
      S_HTAR2: begin
        state_nxt = S_SYNC;
      end
      S_SYNC: begin
        // long wait (0x6) is the only non-terminal code that does not count
        case (lad_bus)
          4'h0: sync_end = 1'b1;
          4'hA: begin
            sync_end = 1'b1;
            sync_err = 1'b1;
          end
          4'h6: ;
          default: begin
            sync_counted = 1'b1;
            if (sync_cnt_inc == LIMIT) go_abort = 1'b1;
          end
        endcase
        if (sync_end) begin
          state_nxt = lat_wr ? S_PTAR1 : S_RDATA0;
        end else if (go_abort) begin
          state_nxt = S_ABORT;
        end
      end
      S_RDATA0: state_nxt = S_RDATA1;
      S_RDATA1: state_nxt = S_PTAR1;
      S_PTAR1:  state_nxt = S_PTAR2;
      S_PTAR2:  state_nxt = S_IDLE;
      S_ABORT: begin
        lframe_o = 1'b0;
        lad_oe   = 1'b1;
        lad_out  = 4'hF;
        if (abort_cnt == 2'd3) state_nxt = S_ABORT_IDLE;
      end
      S_ABORT_IDLE: state_nxt = S_IDLE;
      default:      state_nxt = S_IDLE;
    endcase
  end

  // request latch, SYNC bookkeeping, read capture and completion reporting
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      lat_wr       <= 1'b0;
      lat_addr     <= 16'h0000;
      lat_data     <= 8'h00;
      sync_cnt     <= '0;
      abort_cnt    <= 2'd0;
      pend_status  <= 2'b00;
      rd_shadow    <= 8'h00;
      done_o       <= 1'b0;
      rsp_data_o   <= 8'h00;
      rsp_status_o <= 2'b00;
    end else begin
      done_o <= 1'b0;
      if (accept) begin
        lat_wr      <= req_wr_i;
        lat_addr    <= req_addr_i;
        lat_data    <= req_data_i;
        sync_cnt    <= '0;
        pend_status <= 2'b00;
      end
      if (state == S_SYNC) begin
        if (sync_counted) sync_cnt <= sync_cnt_inc;
        if (sync_err)     pend_status <= 2'b01;
        if (go_abort)     pend_status <= 2'b10;
      end
      abort_cnt <= (state == S_ABORT) ? abort_cnt + 2'd1 : 2'd0;
      if (state == S_RDATA0) rd_shadow[3:0] <= lad_bus;
      if (state == S_RDATA1) rd_shadow[7:4] <= lad_bus;
      // read data is published together with the completion so it never shows a half-updated byte
      if (state == S_PTAR2 || state == S_ABORT_IDLE) begin
        done_o       <= 1'b1;
        rsp_status_o <= pend_status;
        if (state == S_PTAR2 && !lat_wr) rsp_data_o <= rd_shadow;
      end
    end
  end

endmodule

// File: tb/tb_lpc_host.sv
// tb/tb_lpc_host.sv - randomized bench for lpc_host against a cycle-plan reference model
`timescale 1ns/1ps

module tb_lpc_host;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        lframe;
  wire  [3:0]  lad;
  logic        per_oe = 1'b0;
  logic [3:0]  per_val = 4'h0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wr = 1'b0;
  logic [15:0] req_addr = 16'h0;
  logic [7:0]  req_data = 8'h0;
  logic        done;
  logic [7:0]  rsp_data;
  logic [1:0]  rsp_status;
  logic        busy;

  assign lad = per_oe ? per_val : 4'bzzzz;

  lpc_host #(.SYNC_TIMEOUT(TMO)) dut (
    .clk_i       (clk),
    .nrst_i      (nrst),
    .lframe_o    (lframe),
    .lad_bus     (lad),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_wr_i    (req_wr),
    .req_addr_i  (req_addr),
    .req_data_i  (req_data),
    .done_o      (done),
    .rsp_data_o  (rsp_data),
    .rsp_status_o(rsp_status),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // expected outputs for the current cycle
  bit          chk = 1'b0;
  logic        e_lframe = 1'b1;
  logic        e_busy = 1'b0;
  logic        e_ready = 1'b1;
  logic        e_done = 1'b0;
  logic [3:0]  e_lad = 4'h0;
  logic [7:0]  m_rdata = 8'h00;
  logic [1:0]  m_status = 2'b00;

  // compare every cycle, half a period after the state change
  always @(negedge clk) begin
    if (chk) begin
      check("lframe", lframe, e_lframe);
      check("lad", lad, e_lad);
      check("busy", busy, e_busy);
      check("ready", req_ready, e_ready);
      check("done", done, e_done);
      check("rsp_status", rsp_status, m_status);
      check("rsp_data", rsp_data, m_rdata);
    end
  end

  // one entry per bus cycle after acceptance: who owns LAD, the nibble seen there, LFRAME#
  typedef struct {
    bit         host;
    logic [3:0] val;
    bit         frame;
  } cyc_t;

  cyc_t       plan[$];
  logic [3:0] sync_q[$];

  task automatic push(input bit host, input logic [3:0] val, input bit frame);
    cyc_t c;
    c.host  = host;
    c.val   = val;
    c.frame = frame;
    plan.push_back(c);
  endtask

  task automatic build_plan(input bit wr, input logic [15:0] addr, input logic [7:0] data,
                            input logic [3:0] rd_lo, input logic [3:0] rd_hi, output logic [1:0] st);
    int cnt;
    int idx;
    bit ended;
    logic [3:0] v;
    plan.delete();
    cnt   = 0;
    idx   = 0;
    ended = 1'b0;
    st    = 2'b10;
    push(1'b1, 4'h0, 1'b0);
    push(1'b1, wr ? 4'h2 : 4'h0, 1'b1);
    for (int i = 3; i >= 0; i--) push(1'b1, addr[i*4 +: 4], 1'b1);
    if (wr) begin
      push(1'b1, data[3:0], 1'b1);
      push(1'b1, data[7:4], 1'b1);
    end
    push(1'b1, 4'hF, 1'b1);
    push(1'b0, 4'($urandom), 1'b1);
    while (!ended && cnt < TMO) begin
      v = (idx < sync_q.size()) ? sync_q[idx] : 4'hF;
      idx++;
      push(1'b0, v, 1'b1);
      if (v == 4'h0) begin
        st = 2'b00;
        ended = 1'b1;
      end else if (v == 4'hA) begin
        st = 2'b01;
        ended = 1'b1;
      end else if (v != 4'h6) begin
        cnt++;
      end
    end
    if (ended) begin
      if (!wr) begin
        push(1'b0, rd_lo, 1'b1);
        push(1'b0, rd_hi, 1'b1);
      end
      push(1'b0, 4'($urandom), 1'b1);
      push(1'b0, 4'($urandom), 1'b1);
    end else begin
      repeat (4) push(1'b1, 4'hF, 1'b0);
      push(1'b0, 4'($urandom), 1'b1);
    end
  endtask

  task automatic step_plan(input int i);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_wr    = 1'($urandom);
    req_addr  = 16'($urandom);
    req_data  = 8'($urandom);
    per_oe    = !plan[i].host;
    per_val   = plan[i].host ? 4'h0 : plan[i].val;
    e_lframe  = plan[i].frame;
    e_lad     = plan[i].val;
    e_busy    = 1'b1;
    e_ready   = 1'b0;
    e_done    = 1'b0;
  endtask

  task automatic set_idle(input bit with_done);
    per_oe   = 1'b1;
    per_val  = 4'($urandom);
    e_lad    = per_val;
    e_lframe = 1'b1;
    e_busy   = 1'b0;
    e_ready  = 1'b1;
    e_done   = with_done;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      set_idle(1'b0);
    end
  endtask

  // called in an IDLE cycle; returns in the completion cycle
  task automatic run_txn(input bit wr, input logic [15:0] addr, input logic [7:0] data,
                         input logic [3:0] rd_lo, input logic [3:0] rd_hi);
    logic [1:0] st;
    build_plan(wr, addr, data, rd_lo, rd_hi, st);
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_data  = data;
    for (int i = 0; i < plan.size(); i++) step_plan(i);
    @(posedge clk);
    #1;
    set_idle(1'b1);
    m_status = st;
    if (!wr && st != 2'b10) m_rdata = {rd_hi, rd_lo};
  endtask

  function automatic logic [3:0] rand_wait();
    logic [3:0] v;
    v = 4'($urandom_range(1, 15));
    if (v == 4'hA) v = 4'h6;
    return v;
  endfunction

  logic [3:0] t1_lad [9];
  logic [1:0] st_dummy;

  initial begin
    t1_lad = '{4'h0, 4'h2, 4'h0, 4'h0, 4'h8, 4'h0, 4'h5, 4'hA, 4'hF};

    per_oe  = 1'b1;
    per_val = 4'h5;
    repeat (3) @(posedge clk);
    #1;
    check("rst_lframe", lframe, 1'b1);
    check("rst_lad_hiz", lad, 4'h5);
    check("rst_ready", req_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rsp_data", rsp_data, 8'h00);
    check("rst_status", rsp_status, 2'b00);
    nrst = 1'b1;
    set_idle(1'b0);
    chk = 1'b1;
    idle_cycles(2);

    // write 0x0080 <- 0xA5, immediate OK SYNC
    sync_q = {4'h0};
    run_txn(1'b1, 16'h0080, 8'hA5, 4'h0, 4'h0);
    check("t1_latency", plan.size() + 1, 14);
    for (int i = 0; i < 9; i++) check("t1_lad_seq", plan[i].val, t1_lad[i]);
    check("t1_htar2_hiz", plan[9].host, 1'b0);
    check("t1_frame_start", plan[0].frame, 1'b0);
    check("t1_status", rsp_status, 2'b00);

    // back-to-back read 0x004E, nibbles 3 then C
    sync_q = {4'h0};
    run_txn(1'b0, 16'h004E, 8'h00, 4'h3, 4'hC);
    check("t2_rdata", rsp_data, 8'hC3);
    check("t2_status", rsp_status, 2'b00);
    idle_cycles(1);

    // short waits count, long waits do not
    sync_q.delete();
    repeat (3) sync_q.push_back(4'h5);
    repeat (20) sync_q.push_back(4'h6);
    sync_q.push_back(4'h0);
    run_txn(1'b0, 16'h0311, 8'h00, 4'h9, 4'h6);
    check("t3_len", plan.size(), 36);
    check("t3_status", rsp_status, 2'b00);
    check("t3_rdata", rsp_data, 8'h69);

    // stuck SYNC -> abort
    sync_q.delete();
    run_txn(1'b1, 16'h1234, 8'h5A, 4'h0, 4'h0);
    check("t4_len", plan.size(), 31);
    check("t4_status", rsp_status, 2'b10);
    check("t4_rdata_held", rsp_data, 8'h69);
    idle_cycles(2);

    // error SYNC still runs the data phase
    sync_q = {4'hA};
    run_txn(1'b0, 16'h0060, 8'h00, 4'hF, 4'hF);
    check("t5_rdata", rsp_data, 8'hFF);
    check("t5_status", rsp_status, 2'b01);
    idle_cycles(1);

    // reset during the second address nibble
    sync_q = {4'h0};
    build_plan(1'b0, 16'hBEEF, 8'h00, 4'h1, 4'h2, st_dummy);
    req_valid = 1'b1;
    req_wr    = 1'b0;
    req_addr  = 16'hBEEF;
    req_data  = 8'h00;
    for (int i = 0; i < 4; i++) step_plan(i);
    #1;
    chk  = 1'b0;
    nrst = 1'b0;
    per_oe  = 1'b1;
    per_val = 4'h9;
    #1;
    check("mid_rst_lframe", lframe, 1'b1);
    check("mid_rst_lad_hiz", lad, 4'h9);
    check("mid_rst_ready", req_ready, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_rsp_data", rsp_data, 8'h00);
    check("mid_rst_status", rsp_status, 2'b00);
    repeat (2) @(posedge clk);
    #1;
    nrst     = 1'b1;
    m_rdata  = 8'h00;
    m_status = 2'b00;
    set_idle(1'b0);
    chk = 1'b1;
    idle_cycles(3);
    sync_q = {4'h0};
    run_txn(1'b0, 16'h004E, 8'h00, 4'h7, 4'hE);
    check("post_rst_rdata", rsp_data, 8'hE7);

    // randomized traffic
    for (int t = 0; t < 60; t++) begin
      int mode;
      int k;
      mode = $urandom_range(0, 3);
      sync_q.delete();
      case (mode)
        0: sync_q.push_back(4'h0);
        1: begin
          k = $urandom_range(1, 8);
          repeat (k) sync_q.push_back(rand_wait());
          sync_q.push_back($urandom_range(0, 1) ? 4'h0 : 4'hA);
        end
        2: ;
        default: repeat (30) sync_q.push_back(rand_wait());
      endcase
      run_txn(1'($urandom), 16'($urandom), 8'($urandom), 4'($urandom), 4'($urandom));
      idle_cycles($urandom_range(0, 2));
    end

    idle_cycles(2);
    chk = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
